// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if -- request/result bundle for the bit-serial subtractor.
//   master : drives start, a, b, bin; observes busy, done, diff, bout
//   slave  : the subtractor itself
interface serial_subtractor_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (output start, a, b, bin, input  busy, done, diff, bout);
  modport slave  (input  start, a, b, bin, output busy, done, diff, bout);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor -- bit-serial WIDTH-bit subtractor, LSB first, one
// full-subtractor step per clock with a registered borrow.
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : slave side of serial_subtractor_if
//            start/a/b/bin in; busy (RUN), done (1-cycle pulse),
//            diff/bout (last completed result, held) out
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sa_q, sb_q, sr_q, diff_q;
  logic             br_q, bout_q;
  logic [CW-1:0]    cnt_q;

  // full-subtractor cell on the current LSBs
  logic             d_bit, bnext;
  logic [WIDTH-1:0] sr_d;
  always_comb begin
    d_bit = sa_q[0] ^ sb_q[0] ^ br_q;
    bnext = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
    sr_d  = {d_bit, sr_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      case (state_q)
        // DONE hands back to IDLE on its exit edge; that edge also serves as
        // the idle accept so a held start yields one result per WIDTH+1 clks.
        IDLE, DONE: begin
          if (bus.start) begin
            sa_q    <= bus.a;
            sb_q    <= bus.b;
            br_q    <= bus.bin;
            sr_q    <= '0;
            cnt_q   <= '0;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          sr_q  <= sr_d;
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          br_q  <= bnext;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH-1)) begin
            diff_q  <= sr_d;
            bout_q  <= bnext;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
endmodule
